cache_nway_wb: RTL
==================

Name: cache_nway_wb

Overview:
- Parametrised set-associative, write-back, write-allocate cache between the processor word interface and the 128-bit-class line memory interface.
- Successor to the fixed 4-set/2-way cache: configurable way count, set count and line size.
- True-LRU replacement, with invalid ways preferred as victims.
- Hits complete in the request cycle; misses stall the processor until the line has been written back (if dirty) and refilled.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 4, number of sets; power of two, >=2.
- WORDS, 4, 32-bit words per line; power of two, >=2.
- ADDR_W, 30, processor word-address width.
- Derived values:
  - OFS_W = log2(WORDS), IDX_W = log2(SETS).
  - TAG_W = ADDR_W - IDX_W - OFS_W.
  - LINE_W = 32*WORDS.
  - MADDR_W = ADDR_W - OFS_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  processor read request.
- proc_write  in  1  processor write request; never asserted together with proc_read.
- proc_addr  in  ADDR_W  word address: {tag, index, offset}.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  request not complete; the processor holds its request stable while this is high.
- mem_read  out  1  line refill request.
- mem_write  out  1  line write-back request.
- mem_addr  out  MADDR_W  line address.
- mem_wdata  out  LINE_W  write-back line data.
- mem_rdata  in  LINE_W  refill line data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current read or write this cycle.

Behaviour:
- Storage per set/way: valid, dirty, tag, line; age[log2(WAYS)] per way per set.
- Reset (asynchronous, on proc_reset_n=0):
  - All valid and dirty bits cleared; line data is don't-care.
  - Age of way w set to w.
  - State forced to IDLE.
  - Outputs go low immediately, since mem_* and proc_stall decode combinationally from state and request; mem_addr and mem_wdata are 0.
  - Reset during WRITE_BACK or ALLOCATE abandons the transfer; memory must tolerate the dropped request.
- Hit: a way in the set is valid and its tag matches.
  - proc_stall = request & (~hit | state!=IDLE).
  - proc_rdata = word[offset] of the hit way, combinational; it is the way selected for a victim when there is no hit.
- Write hit in IDLE: word merged at the clock edge, dirty set, no stall.
- LRU update on a hit (IDLE) or on a fill:
  - The accessed way's age becomes 0.
  - Every way with an age below the accessed way's old age increments.
  - Ages in a set always remain a permutation of 0..WAYS-1.
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS-1. The victim is registered on the miss edge.
- FSM states:
  - IDLE: on request & ~hit, go to WRITE_BACK if the victim is valid and dirty, else ALLOCATE.
  - WRITE_BACK:
    - mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line.
    - On mem_ready, go to ALLOCATE; otherwise hold.
  - ALLOCATE:
    - mem_read=1, mem_addr=proc_addr[ADDR_W-1:OFS_W].
    - On mem_ready: victim gets valid=1, tag=addr tag, dirty=proc_write, line=mem_rdata (with proc_wdata merged at offset for a write). LRU is updated and the FSM returns to IDLE.
- The request completes as a hit in the cycle after the refill edge. Clean-miss stall cycles = 1 + the number of ALLOCATE cycles, including the mem_ready cycle.
- mem_read and mem_write are never high together. Both are low in IDLE.
- A request withdrawn mid-miss still completes the fill. The next request is evaluated fresh in IDLE.
- WAYS=1: the age logic is degenerate (width 0, always way 0) and the design must still elaborate.

Optional Feature:
- CACHE_PERF_CNT_EN:
  - Adds outputs perf_hit[31:0] and perf_miss[31:0].
  - perf_hit counts cycles in IDLE with request&hit.
  - perf_miss counts IDLE->miss transitions.
  - Both are cleared by reset and saturate at 0xFFFFFFFF.
- Without the macro these ports and counters do not exist.

Test Plan:
- Reset, then read 0x00000010 (set 0 for WAYS=2/SETS=4/WORDS=4) with mem_ready after 3 cycles returning 0x...4444_3333_2222_1111. Expected: mem_read asserted, mem_addr=0x0000004, stall for 4 cycles, then proc_rdata=0x11111111.
- Write 0xDEADBEEF to a hit line: no stall. A later eviction of that line shows mem_write=1, mem_addr=old line address, and the line carrying 0xDEADBEEF before mem_read.
- Fill set 1 with tags A and B, read A, then miss on tag C. Expected: B evicted (LRU); A still hits with 0 stall.
- WAYS=4: four distinct tags into one set fill ways 0..3 in order. The fifth tag evicts way 0 unless it was re-accessed.
- Assert proc_reset_n=0 mid-WRITE_BACK. Expected: mem_write falls in the same cycle, proc_stall low with no request, and all lookups miss after release.
- CACHE_PERF_CNT_EN: 3 hits and 2 misses give perf_hit=3 and perf_miss=2.

Source files
------------

// File: rtl/cache_nway_wb_if.sv
// Processor/memory bus bundle for cache_nway_wb.
// slave  : the cache's view (takes processor requests, drives the memory side).
// master : the environment's view (processor plus line memory).
interface cache_nway_wb_if #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4
);
    localparam int OFS_W   = $clog2(WORDS);
    localparam int LINE_W  = 32 * WORDS;
    localparam int MADDR_W = ADDR_W - OFS_W;

    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    logic [31:0]         proc_wdata;
    logic [31:0]         proc_rdata;
    logic                proc_stall;
    logic                mem_read;
    logic                mem_write;
    logic [MADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_nway_wb.sv
// Set-associative write-back / write-allocate cache with true-LRU replacement.
// Hits complete in the request cycle; misses stall through write-back and refill.
// Optional macro CACHE_PERF_CNT_EN adds saturating hit/miss counters
// (perf_hit, perf_miss).
module cache_nway_wb #(
    parameter int WAYS   = 2,
    parameter int SETS   = 4,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 30
) (
    input  logic           clk,
    input  logic           proc_reset_n,
    cache_nway_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]    perf_hit,
    output logic [31:0]    perf_miss
`endif
);
    localparam int OFS_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFS_W;
    localparam int LINE_W  = 32 * WORDS;
    localparam int MADDR_W = ADDR_W - OFS_W;
    // A single way still needs a 1-bit age/way field; it is always 0.
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]  line_q  [SETS][WAYS];
    logic [WAY_W-1:0]   age_q   [SETS][WAYS];

    // Victim way and line address latched on the miss edge, so an abandoned
    // request cannot redirect an in-flight transfer.
    logic [WAY_W-1:0]   victim_q;
    logic [MADDR_W-1:0] laddr_q;

    logic [IDX_W-1:0]   idx, fidx;
    logic [TAG_W-1:0]   tag, ftag;
    logic [OFS_W+4:0]   ofs_bit;
    logic               req, idle, hit, found;
    logic [WAY_W-1:0]   hit_way, vict, rd_way;
    logic               acc, miss_start, wr_hit, fill;
    logic [IDX_W-1:0]   lru_set;
    logic [WAY_W-1:0]   lru_way, lru_old;
    logic [LINE_W-1:0]  fill_line;

    assign idx     = bus.proc_addr[OFS_W +: IDX_W];
    assign tag     = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign ofs_bit = {bus.proc_addr[OFS_W-1:0], 5'b0};
    assign fidx    = laddr_q[IDX_W-1:0];
    assign ftag    = laddr_q[MADDR_W-1:IDX_W];

    assign req        = bus.proc_read | bus.proc_write;
    assign idle       = (state_q == IDLE);
    assign acc        = idle & req & hit;
    assign miss_start = idle & req & ~hit;
    assign wr_hit     = idle & bus.proc_write & hit;
    assign fill       = (state_q == ALLOCATE) & bus.mem_ready;

    // Tag compare across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way.
    always_comb begin
        vict  = '0;
        found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[idx][w]) begin
                found = 1'b1;
                vict  = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found && age_q[idx][w] == WAY_W'(WAYS - 1))
                vict = WAY_W'(w);
        end
    end

    assign rd_way         = hit ? hit_way : vict;
    assign bus.proc_rdata = line_q[idx][rd_way][ofs_bit +: 32];
    assign bus.proc_stall = req & (~hit | ~idle);

    // LRU touch: a hit in IDLE or the refill of the victim way.
    assign lru_set = fill ? fidx : idx;
    assign lru_way = fill ? victim_q : hit_way;
    assign lru_old = age_q[lru_set][lru_way];

    // Refill line with the pending write word merged in.
    always_comb begin
        fill_line = bus.mem_rdata;
        if (bus.proc_write)
            fill_line[ofs_bit +: 32] = bus.proc_wdata;
    end

    // Next state and memory-side outputs, decoded from state only.
    always_comb begin
        state_d       = state_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (miss_start)
                    state_d = (valid_q[idx][vict] && dirty_q[idx][vict]) ? WRITE_BACK : ALLOCATE;
            end
            WRITE_BACK: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {tag_q[fidx][victim_q], fidx};
                bus.mem_wdata = line_q[fidx][victim_q];
                if (bus.mem_ready)
                    state_d = ALLOCATE;
            end
            ALLOCATE: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = laddr_q;
                if (bus.mem_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid/dirty bits and LRU ages.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            laddr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                victim_q <= vict;
                laddr_q  <= bus.proc_addr[ADDR_W-1:OFS_W];
            end
            if (wr_hit)
                dirty_q[idx][hit_way] <= 1'b1;
            if (fill) begin
                valid_q[fidx][victim_q] <= 1'b1;
                dirty_q[fidx][victim_q] <= bus.proc_write;
            end
            if (acc || fill) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == lru_way)
                        age_q[lru_set][w] <= '0;
                    else if (age_q[lru_set][w] < lru_old)
                        age_q[lru_set][w] <= age_q[lru_set][w] + 1'b1;
                end
            end
        end
    end

    // Tag and line storage; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (wr_hit)
            line_q[idx][hit_way][ofs_bit +: 32] <= bus.proc_wdata;
        if (fill) begin
            tag_q[fidx][victim_q]  <= ftag;
            line_q[fidx][victim_q] <= fill_line;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] perf_hit_q, perf_miss_q;

    // Saturating hit-cycle and miss-event counters.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (acc && perf_hit_q != 32'hFFFF_FFFF)
                perf_hit_q <= perf_hit_q + 32'd1;
            if (miss_start && perf_miss_q != 32'hFFFF_FFFF)
                perf_miss_q <= perf_miss_q + 32'd1;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif
endmodule
